imem_loader_ctrl: RTL and testbench
===================================

# imem_loader_ctrl

Sequencer and port arbiter for the single-cycle core's 2048-word instruction memory. It receives a program as a little-endian byte stream (valid/ready), packs four bytes into each 32-bit word and issues one write per word to the memory's write port. While loading, it holds the core in reset and blocks fetches. When the load completes, it hands the memory to the core's fetch path. It sits between the top-level boot/debug byte source, the instruction memory and the core's PC.

## Interface
Parameters:
- DEPTH, 2048, number of 32-bit words in instruction memory.
- ADDR_W, 11, word-address width; equals log2(DEPTH).
- BOOT_RUN, 1, reset state selector: 1 = enter RUN after reset (memory preloaded from hex file); 0 = enter IDLE with the core held.

Ports:
- i_clk  in  1  single clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_load_start  in  1  one-cycle request to begin a load.
- i_len_words  in  ADDR_W+1  words to load; sampled on the cycle i_load_start is accepted.
- i_byte_valid  in  1  byte-stream valid.
- i_byte  in  8  byte-stream data.
- o_byte_ready  out  1  byte accepted when i_byte_valid and o_byte_ready are both high.
- o_imem_we  out  1  one-cycle word write strobe.
- o_imem_waddr  out  32  byte address of the write; word index << 2, so bits [1:0] are always 0.
- o_imem_wdata  out  32  packed write word.
- i_cpu_addr  in  32  core fetch address (PC).
- o_imem_raddr  out  32  read address to memory: i_cpu_addr in RUN, else 0.
- o_cpu_rst_n  out  1  core reset; low in every state except RUN.
- o_busy  out  1  high in LOAD and WRITE.
- o_done  out  1  one-cycle pulse on the IDLE/WRITE→RUN transition of a load.
- o_err  out  1  sticky length error; cleared only by the next accepted i_load_start with a legal length.

## Operation
- States: IDLE, LOAD, WRITE, RUN.
- Reset state: RUN if BOOT_RUN=1, else IDLE.
- Reset values of outputs: o_byte_ready=0, o_imem_we=0, o_imem_waddr=0, o_imem_wdata=0, o_busy=0, o_done=0, o_err=0. o_cpu_rst_n = (BOOT_RUN ? 1 : 0).
- i_load_start is accepted in IDLE or RUN. It is ignored in LOAD and WRITE.
- On accept, the length is checked:
  - i_len_words > DEPTH: o_err=1 next cycle; go to IDLE.
  - i_len_words == 0: o_done pulse; go to RUN.
  - Otherwise: latch the length, clear the word counter and byte counter, clear o_err, go to LOAD.
- LOAD:
  - o_byte_ready=1.
  - Each accepted byte goes to wdata[8*k+7:8*k], where k is the 2-bit byte counter; first byte lands in [7:0].
  - On the 4th byte (k==3), go to WRITE.
- WRITE (exactly one cycle):
  - o_imem_we=1, o_imem_waddr = word_cnt<<2, o_imem_wdata = packed word.
  - o_byte_ready=0.
  - Then word_cnt increments. If the new count equals the latched length, pulse o_done and go to RUN; else go to LOAD.
- RUN: o_cpu_rst_n=1, o_imem_raddr = i_cpu_addr, o_byte_ready=0.
- Bytes presented outside LOAD are not consumed (ready=0). Bytes are never dropped.
- Reset asserted mid-load: everything aborts immediately. Memory keeps the words already written. No partial word is written.

## Timing
- Accept of i_load_start in cycle N: state=LOAD and o_byte_ready=1 in N+1. o_cpu_rst_n falls in N+1.
- 4th byte accepted in cycle M: o_imem_we=1 in M+1. The next byte can be accepted in M+2 at the earliest.
- Peak throughput: 1 word per 5 cycles.
- Last write in cycle W: o_done=1 and o_cpu_rst_n=1 in W+1. o_imem_raddr follows i_cpu_addr combinationally from W+1.
- o_imem_raddr and o_cpu_rst_n decode from state; all other outputs are registered.
- word_cnt is ADDR_W+1 bits wide, so a full DEPTH-word load ends with the counter at DEPTH, with no wrap.
- i_load_start asserted on the same cycle as the final WRITE is ignored; the block enters RUN.

## Structure
- Shared package imem_pkg:
  - DEPTH_DEF, ADDR_W_DEF.
  - Typedef ldr_state_e (IDLE, LOAD, WRITE, RUN).
- One natural sub-module: byte_packer (byte counter plus 4×8 shift/assemble register, with a word_full flag).
- The write port of instruction_memory gains i_we/i_waddr/i_wdata, driven from this block.

## Test plan
- BOOT_RUN=1, reset release → o_cpu_rst_n=1 in the first cycle; o_imem_raddr tracks i_cpu_addr=0x0000_0010; o_byte_ready=0.
- BOOT_RUN=0, load len=2, bytes 78 56 34 12 EF BE AD DE with valid held high → writes 0x12345678 @0x0, then 0xDEADBEEF @0x4. o_done is one cycle after the second write, and o_cpu_rst_n rises on that same cycle.
- Valid toggled every other cycle during the load → same two words written, no byte lost or duplicated; o_byte_ready=0 during each WRITE cycle.
- len=2049 → o_err=1, state IDLE, no o_imem_we. A following len=1 load clears o_err and completes.
- Load started from RUN, then i_reset pulsed after 6 bytes → one write only (word 0). After reset, state follows BOOT_RUN; o_err=0.
- len=0 from IDLE → o_done pulse next cycle, RUN, zero writes; i_load_start during LOAD is ignored (the length is not re-latched).

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader.
package imem_pkg;

  localparam int unsigned DEPTH_DEF  = 2048;
  localparam int unsigned ADDR_W_DEF = 11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WRITE,
    RUN
  } ldr_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; first byte lands in [7:0].
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // word_o includes the byte being pushed this cycle, so the 4th byte's word
  // is complete on the same edge that accepts it.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (push_i) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  assign word_o      = word_d;
  assign word_full_o = push_i && !clear_i && (cnt_q == 2'd3);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader_ctrl.sv
// Loads a program byte stream into instruction memory while holding the core in
// reset, then hands the memory read port to the core's fetch path.
module imem_loader_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter bit          BOOT_RUN = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_load_start,
  input  logic [ADDR_W:0] i_len_words,
  input  logic            i_byte_valid,
  input  logic [7:0]      i_byte,
  output logic            o_byte_ready,
  output logic            o_imem_we,
  output logic [31:0]     o_imem_waddr,
  output logic [31:0]     o_imem_wdata,
  input  logic [31:0]     i_cpu_addr,
  output logic [31:0]     o_imem_raddr,
  output logic            o_cpu_rst_n,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_err
);

  localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_W       = (ADDR_W + 1)'(1);
  localparam ldr_state_e      RESET_STATE = BOOT_RUN ? RUN : IDLE;

  ldr_state_e      state_q;
  logic [ADDR_W:0] len_q;
  logic [ADDR_W:0] word_cnt_q;
  logic [ADDR_W:0] word_inc;
  logic            ready_q;
  logic            we_q;
  logic [31:0]     waddr_q;
  logic [31:0]     wdata_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            start_acc;
  logic            byte_acc;
  logic [31:0]     packed_word;
  logic            word_full;

  assign start_acc = i_load_start && ((state_q == IDLE) || (state_q == RUN));
  // ready_q is only ever high in LOAD, so this is also the LOAD-state accept.
  assign byte_acc  = i_byte_valid && ready_q;
  assign word_inc  = word_cnt_q + ONE_W;

  byte_packer u_byte_packer (
    .clk_i       (i_clk),
    .rst_ni      (i_reset),
    .clear_i     (start_acc),
    .push_i      (byte_acc),
    .byte_i      (i_byte),
    .word_o      (packed_word),
    .word_full_o (word_full)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= RESET_STATE;
      len_q      <= '0;
      word_cnt_q <= '0;
      ready_q    <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, RUN: begin
          if (i_load_start) begin
            if (i_len_words > DEPTH_W) begin
              err_q   <= 1'b1;
              state_q <= IDLE;
            end else if (i_len_words == '0) begin
              err_q   <= 1'b0;
              done_q  <= 1'b1;
              state_q <= RUN;
            end else begin
              err_q      <= 1'b0;
              len_q      <= i_len_words;
              word_cnt_q <= '0;
              ready_q    <= 1'b1;
              busy_q     <= 1'b1;
              state_q    <= LOAD;
            end
          end
        end
        LOAD: begin
          if (word_full) begin
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            waddr_q <= 32'(word_cnt_q) << 2;
            wdata_q <= packed_word;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          word_cnt_q <= word_inc;
          if (word_inc == len_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= RUN;
          end else begin
            ready_q <= 1'b1;
            state_q <= LOAD;
          end
        end
      endcase
    end
  end

  assign o_byte_ready = ready_q;
  assign o_imem_we    = we_q;
  assign o_imem_waddr = waddr_q;
  assign o_imem_wdata = wdata_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_cpu_rst_n  = (state_q == RUN);
  assign o_imem_raddr = (state_q == RUN) ? i_cpu_addr : 32'd0;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench: dut0 boots to IDLE, dut1 boots to RUN; monitors check writes.
module tb_imem_loader_ctrl;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  logic        clk;
  logic        rst_n     [2];
  logic        start     [2];
  logic        valid     [2];
  logic [11:0] len_words;
  logic [7:0]  cur_byte;
  logic [31:0] cpu_addr;

  logic        ready     [2];
  logic        we        [2];
  logic [31:0] waddr     [2];
  logic [31:0] wdata     [2];
  logic [31:0] raddr     [2];
  logic        cpu_rst_n [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];

  int  vectors     = 0;
  int  miscompares = 0;
  int  done_cnt    [2];
  wr_t exp_q0 [$];
  wr_t exp_q1 [$];

  imem_loader_ctrl #(.DEPTH(2048), .ADDR_W(11), .BOOT_RUN(1'b0)) dut0 (
    .i_clk(clk), .i_reset(rst_n[0]), .i_load_start(start[0]), .i_len_words(len_words),
    .i_byte_valid(valid[0]), .i_byte(cur_byte), .o_byte_ready(ready[0]),
    .o_imem_we(we[0]), .o_imem_waddr(waddr[0]), .o_imem_wdata(wdata[0]),
    .i_cpu_addr(cpu_addr), .o_imem_raddr(raddr[0]), .o_cpu_rst_n(cpu_rst_n[0]),
    .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0])
  );

  imem_loader_ctrl #(.DEPTH(2048), .ADDR_W(11), .BOOT_RUN(1'b1)) dut1 (
    .i_clk(clk), .i_reset(rst_n[1]), .i_load_start(start[1]), .i_len_words(len_words),
    .i_byte_valid(valid[1]), .i_byte(cur_byte), .o_byte_ready(ready[1]),
    .o_imem_we(we[1]), .o_imem_waddr(waddr[1]), .o_imem_wdata(wdata[1]),
    .i_cpu_addr(cpu_addr), .o_imem_raddr(raddr[1]), .o_cpu_rst_n(cpu_rst_n[1]),
    .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int d, input logic [31:0] a, input logic [31:0] w, input bit last);
    wr_t e;
    e.addr = a;
    e.data = w;
    e.last = last;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic pop_exp(input int d, output wr_t e, output bit ok);
    ok = 1'b0;
    e  = '0;
    if (d == 0 && exp_q0.size() > 0) begin e = exp_q0.pop_front(); ok = 1'b1; end
    if (d == 1 && exp_q1.size() > 0) begin e = exp_q1.pop_front(); ok = 1'b1; end
  endtask

  // Monitors: every write must match the next expected entry; the write that
  // ends a load must be followed next cycle by done with the core released.
  for (genvar g = 0; g < 2; g++) begin : g_mon
    bit pend;
    always @(negedge clk) begin
      wr_t e;
      bit  ok;
      if (pend) check($sformatf("dut%0d done+cpu_rst_n after last write", g),
                      {30'd0, done[g], cpu_rst_n[g]}, 32'd3);
      pend = 1'b0;
      if (done[g]) done_cnt[g]++;
      if (we[g]) begin
        pop_exp(g, e, ok);
        if (!ok) begin
          vectors++;
          miscompares++;
          $display("FAIL dut%0d unexpected write: got addr 0x%08h data 0x%08h, required none",
                   g, waddr[g], wdata[g]);
        end else begin
          check($sformatf("dut%0d waddr", g), waddr[g], e.addr);
          check($sformatf("dut%0d wdata", g), wdata[g], e.data);
          check($sformatf("dut%0d ready during write", g), {31'd0, ready[g]}, 32'd0);
          pend = e.last;
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_load(input int d, input logic [11:0] len);
    len_words = len;
    start[d]  = 1'b1;
    tick();
    start[d]  = 1'b0;
  endtask

  task automatic send_bytes(input int d, input logic [63:0] bytes, input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      int t;
      cur_byte = bytes[8*i +: 8];
      valid[d] = 1'b1;
      t = 0;
      while (!ready[d] && t < 50) begin
        tick();
        t++;
      end
      if (!ready[d]) begin
        vectors++;
        miscompares++;
        $display("FAIL dut%0d byte %0d accept: got no ready in 50 cycles, required ready", d, i);
        valid[d] = 1'b0;
        return;
      end
      tick();
      if (toggle) begin
        valid[d] = 1'b0;
        tick();
      end
    end
    valid[d] = 1'b0;
  endtask

  initial begin
    rst_n[0] = 1'b0; rst_n[1] = 1'b0;
    start[0] = 1'b0; start[1] = 1'b0;
    valid[0] = 1'b0; valid[1] = 1'b0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    len_words = '0;
    cur_byte  = '0;
    cpu_addr  = 32'h0000_0010;
    tick(2);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Reset state: dut1 boots into RUN, dut0 into IDLE.
    check("boot1 cpu_rst_n", {31'd0, cpu_rst_n[1]}, 32'd1);
    check("boot1 raddr", raddr[1], 32'h0000_0010);
    check("boot1 ready", {31'd0, ready[1]}, 32'd0);
    check("boot1 busy/err", {30'd0, busy[1], err[1]}, 32'd0);
    check("boot0 cpu_rst_n", {31'd0, cpu_rst_n[0]}, 32'd0);
    check("boot0 raddr", raddr[0], 32'd0);
    check("boot0 ready/done/err", {29'd0, ready[0], done[0], err[0]}, 32'd0);
    check("boot0 waddr|wdata", waddr[0] | wdata[0], 32'd0);

    // Two-word load, valid held high.
    push_exp(0, 32'h0, 32'h1234_5678, 1'b0);
    push_exp(0, 32'h4, 32'hDEAD_BEEF, 1'b1);
    start_load(0, 12'd2);
    check("load ready after start", {31'd0, ready[0]}, 32'd1);
    check("load busy/cpu_rst_n", {30'd0, busy[0], cpu_rst_n[0]}, 32'd2);
    send_bytes(0, 64'hDEAD_BEEF_1234_5678, 8, 1'b0);
    tick(3);
    check("after load cpu_rst_n", {31'd0, cpu_rst_n[0]}, 32'd1);
    check("after load raddr", raddr[0], 32'h0000_0010);

    // Same words again from RUN with valid toggling.
    push_exp(0, 32'h0, 32'h1234_5678, 1'b0);
    push_exp(0, 32'h4, 32'hDEAD_BEEF, 1'b1);
    start_load(0, 12'd2);
    check("reload cpu_rst_n low", {31'd0, cpu_rst_n[0]}, 32'd0);
    send_bytes(0, 64'hDEAD_BEEF_1234_5678, 8, 1'b1);
    tick(3);
    check("done count after toggled load", done_cnt[0], 32'd2);

    // Over-length request.
    start_load(0, 12'd2049);
    check("len 2049 err", {31'd0, err[0]}, 32'd1);
    check("len 2049 idle", {29'd0, busy[0], cpu_rst_n[0], ready[0]}, 32'd0);
    tick(4);
    push_exp(0, 32'h0, 32'h0403_0201, 1'b1);
    start_load(0, 12'd1);
    check("len 1 clears err", {31'd0, err[0]}, 32'd0);
    send_bytes(0, 64'h0403_0201, 4, 1'b0);
    tick(3);
    check("done count after len 1", done_cnt[0], 32'd3);

    // Reset mid-load on the RUN-booting instance: only word 0 is written.
    push_exp(1, 32'h0, 32'h4433_2211, 1'b0);
    start_load(1, 12'd3);
    send_bytes(1, 64'h0000_6655_4433_2211, 6, 1'b0);
    rst_n[1] = 1'b0;
    tick();
    rst_n[1] = 1'b1;
    tick();
    check("post-reset boot1 cpu_rst_n", {31'd0, cpu_rst_n[1]}, 32'd1);
    check("post-reset boot1 busy/ready/err", {29'd0, busy[1], ready[1], err[1]}, 32'd0);
    check("post-reset boot1 raddr", raddr[1], 32'h0000_0010);

    // Zero-length load from IDLE.
    start_load(0, 12'd4000);
    check("len 4000 idle", {31'd0, cpu_rst_n[0]}, 32'd0);
    tick(2);
    start_load(0, 12'd0);
    check("len 0 done+run", {30'd0, done[0], cpu_rst_n[0]}, 32'd3);
    tick();
    check("len 0 done is one pulse", {31'd0, done[0]}, 32'd0);

    // Start during LOAD must not re-latch the length.
    push_exp(0, 32'h0, 32'hCAFE_F00D, 1'b1);
    start_load(0, 12'd1);
    send_bytes(0, 64'hF00D, 2, 1'b0);
    start_load(0, 12'd3);
    send_bytes(0, 64'hCAFE, 2, 1'b0);
    tick(3);
    check("ignored start: back in RUN", {31'd0, cpu_rst_n[0]}, 32'd1);
    check("done count total", done_cnt[0], 32'd5);

    // Full-depth length is legal; reset aborts it.
    start_load(0, 12'd2048);
    check("len 2048 accepted", {29'd0, err[0], busy[0], ready[0]}, 32'd3);
    rst_n[0] = 1'b0;
    #1;
    check("async reset abort", {28'd0, busy[0], ready[0], we[0], cpu_rst_n[0]}, 32'd0);
    tick();
    rst_n[0] = 1'b1;
    tick(2);

    check("dut0 pending writes", exp_q0.size(), 32'd0);
    check("dut1 pending writes", exp_q1.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
